// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core.
// Holds SR(12), Cause(13), EPC(14) and the read-only PRId(15). It raises int_req
// toward the pipeline and the exception-PC selector, and captures the victim PC
// into EPC when an interrupt is accepted.
module cp0_unit #(
  parameter logic [31:0] PRID_VAL = 32'h0000_4D49,
  parameter int          HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          addr,
  input  logic [31:0]         din,
  input  logic                we,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                exl_set,
  input  logic                exl_clr,
  input  logic [31:0]         intpc,
  output logic [31:0]         dout,
  output logic [29:0]         epc,
  output logic                int_req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Interrupt fields start at bit 10 in both SR (IM) and Cause (IP).
  localparam int INT_LSB = 10;

  logic [HW_INT_W-1:0] intMask;   // SR.IM
  logic                exlBit;    // SR.EXL
  logic                ieBit;     // SR.IE
  logic [HW_INT_W-1:0] intPend;   // Cause.IP
  logic [29:0]         epcReg;    // EPC[31:2]

  logic srWrite;
  logic epcWrite;

  assign srWrite  = we && (addr == ADDR_SR);
  assign epcWrite = we && (addr == ADDR_EPC);

  // Cause.IP: single-stage synchronizer of the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    if (!rst_n) intPend <= '0;
    else        intPend <= hw_int;
  end

  // SR and EPC: interrupt entry beats eret, which beats a software mtc0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intMask <= '0;
      exlBit  <= 1'b0;
      ieBit   <= 1'b0;
      epcReg  <= '0;
    end else if (exl_set) begin
      // Interrupt entry: any mtc0 to SR/EPC retiring alongside is dropped.
      exlBit <= 1'b1;
      epcReg <= intpc[31:2];
    end else begin
      if (srWrite) begin
        intMask <= din[INT_LSB +: HW_INT_W];
        ieBit   <= din[0];
      end
      // eret owns EXL this cycle; an mtc0 to SR only keeps its IM/IE part.
      if (exl_clr)      exlBit <= 1'b0;
      else if (srWrite) exlBit <= din[1];
      if (epcWrite) epcReg <= din[31:2];
    end
  end

  // Interrupt request from registered state only; masked while inside a handler.
  assign int_req = (|(intPend & intMask)) & ieBit & ~exlBit;
  assign epc     = epcReg;

  // mfc0 read mux; unimplemented registers and bits read as zero.
  always_comb begin
    // NOTE: default first so every path assigns dout and no latch is inferred.
    dout = '0;
    case (addr)
      ADDR_SR: begin
        dout[INT_LSB +: HW_INT_W] = intMask;
        dout[1]                   = exlBit;
        dout[0]                   = ieBit;
      end
      ADDR_CAUSE: dout[INT_LSB +: HW_INT_W] = intPend;
      ADDR_EPC:   dout = {epcReg, 2'b00};
      ADDR_PRID:  dout = PRID_VAL;
      default:    dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: reset, a table of directed single-edge
// vectors, hand-written multi-cycle sequences, then randomized traffic compared
// against a register-file model of the CP0 rules.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_4D49;
  localparam logic [31:0] SR_WMASK  = 32'h0000_FC03;
  localparam logic [31:0] EPC_WMASK = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        we;
  logic [5:0]  hw_int;
  logic        exl_set;
  logic        exl_clr;
  logic [31:0] intpc;
  logic [31:0] dout;
  logic [29:0] epc;
  logic        int_req;

  int errors = 0;
  int checks = 0;

  cp0_unit dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we),
    .hw_int(hw_int), .exl_set(exl_set), .exl_clr(exl_clr), .intpc(intpc),
    .dout(dout), .epc(epc), .int_req(int_req)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model: CP0 as a 32-entry register file --------
  logic [31:0] mRegs [32];

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd15)                 return PRID;
    if (a >= 5'd12 && a <= 5'd14)   return mRegs[a];
    return 32'h0;
  endfunction

  function automatic logic modelIrq();
    logic [31:0] sr;
    sr = mRegs[12];
    return (((sr & mRegs[13]) & 32'h0000_FC00) != 0) && sr[0] && !sr[1];
  endfunction

  // One clock edge: compute the new register file from the old one.
  task automatic modelEdge(input logic w, input logic [4:0] a, input logic [31:0] d,
                           input logic [5:0] hw, input logic es, input logic ec,
                           input logic [31:0] pc);
    logic [31:0] nxt [32];
    for (int i = 0; i < 32; i++) nxt[i] = mRegs[i];
    nxt[13] = {16'h0, hw, 10'h0};
    if (es) begin
      nxt[12] = mRegs[12] | 32'h2;
      nxt[14] = pc & EPC_WMASK;
    end else begin
      if (w && a == 5'd12) nxt[12] = d & SR_WMASK;
      if (w && a == 5'd14) nxt[14] = d & EPC_WMASK;
      if (ec) nxt[12] = nxt[12] & ~32'h2;
      if (ec && w && a == 5'd12) nxt[12] = (d & 32'h0000_FC01);
    end
    for (int i = 0; i < 32; i++) mRegs[i] = nxt[i];
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [5:0]  hw;
    logic        es;
    logic        ec;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] expDout;
    logic [29:0] expEpc;
    logic        expIrq;
  } vec_t;

  vec_t vecs [13];

  task automatic idleInputs();
    we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0; din = '0; intpc = '0;
  endtask

  initial begin
    rst_n = 1'b0; addr = 5'd12; hw_int = '0;
    idleInputs();

    vecs[0]  = '{1'b1, 5'd12, 32'h0000_FC01, 6'b000000, 1'b0, 1'b0, 32'h0,         5'd12, 32'h0000_FC01, 30'h0,         1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         6'b000100, 1'b0, 1'b0, 32'h0,         5'd13, 32'h0000_1000, 30'h0,         1'b1};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         6'b000100, 1'b1, 1'b0, 32'h0000_3008, 5'd14, 32'h0000_3008, 30'hC02,       1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         6'b000100, 1'b0, 1'b0, 32'h0,         5'd12, 32'h0000_FC03, 30'hC02,       1'b0};
    vecs[4]  = '{1'b1, 5'd14, 32'hDEAD_BEEC, 6'b000100, 1'b1, 1'b0, 32'h0000_3010, 5'd14, 32'h0000_3010, 30'hC04,       1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         6'b000100, 1'b0, 1'b1, 32'h0,         5'd12, 32'h0000_FC01, 30'hC04,       1'b1};
    vecs[6]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 6'b000001, 1'b0, 1'b0, 32'h0,         5'd13, 32'h0000_0400, 30'hC04,       1'b1};
    vecs[7]  = '{1'b1, 5'd15, 32'hFFFF_FFFF, 6'b000000, 1'b0, 1'b0, 32'h0,         5'd15, 32'h0000_4D49, 30'hC04,       1'b0};
    vecs[8]  = '{1'b1, 5'd12, 32'hFFFF_FFFE, 6'b111111, 1'b0, 1'b1, 32'h0,         5'd12, 32'h0000_FC00, 30'hC04,       1'b0};
    vecs[9]  = '{1'b1, 5'd14, 32'h1234_567B, 6'b111111, 1'b0, 1'b0, 32'h0,         5'd14, 32'h1234_5678, 30'h048D159E,  1'b0};
    vecs[10] = '{1'b1, 5'd12, 32'h0000_0401, 6'b111111, 1'b0, 1'b0, 32'h0,         5'd12, 32'h0000_0401, 30'h048D159E,  1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         6'b111111, 1'b1, 1'b1, 32'h0000_8003, 5'd14, 32'h0000_8000, 30'h2000,      1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         6'b000000, 1'b0, 1'b0, 32'h0,         5'd5,  32'h0000_0000, 30'h2000,      1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout12", dout, 32'h0);
    addr = 5'd13; #1; check("reset_dout13", dout, 32'h0);
    addr = 5'd14; #1; check("reset_dout14", dout, 32'h0);
    check("reset_epc", {2'b00, epc}, 32'h0);
    check("reset_int_req", {31'h0, int_req}, 32'h0);
    rst_n = 1'b1;

    // Table: drive a row, take one edge, then read back with the bus idle.
    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din; hw_int = vecs[i].hw;
      exl_set = vecs[i].es; exl_clr = vecs[i].ec; intpc = vecs[i].pc;
      @(posedge clk);
      #1;
      idleInputs();
      addr = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_dout", i), dout, vecs[i].expDout);
      check($sformatf("vec%0d_epc", i), {2'b00, epc}, {2'b00, vecs[i].expEpc});
      check($sformatf("vec%0d_int_req", i), {31'h0, int_req}, {31'h0, vecs[i].expIrq});
    end

    // Interrupt latency: exactly one edge, no combinational hw_int path.
    we = 1'b1; addr = 5'd12; din = 32'h0000_FC01; hw_int = 6'b000000;
    @(posedge clk); #1;
    idleInputs();
    hw_int = 6'b000100;
    #3;
    check("lat_before_edge", {31'h0, int_req}, 32'h0);
    @(posedge clk); #1;
    check("lat_after_edge", {31'h0, int_req}, 32'h1);

    // Mid-cycle asynchronous reset with EPC loaded and an interrupt pending.
    we = 1'b1; addr = 5'd14; din = 32'h0040_0010;
    @(posedge clk); #1;
    idleInputs();
    addr = 5'd12;
    #1;
    check("pre_rst_epc", {2'b00, epc}, 32'h0010_0004);
    check("pre_rst_int_req", {31'h0, int_req}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_epc", {2'b00, epc}, 32'h0);
    check("async_rst_int_req", {31'h0, int_req}, 32'h0);
    check("async_rst_dout12", dout, 32'h0);
    @(posedge clk); #1;
    hw_int = '0;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    modelReset();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = 5'd12;
        2:       a = 5'd13;
        3:       a = 5'd14;
        4:       a = 5'd15;
        default: a = 5'($urandom_range(0, 31));
      endcase
      addr    = a;
      we      = 1'($urandom_range(0, 1));
      din     = $urandom;
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom_range(0, 63));
      exl_set = ($urandom_range(0, 7) == 0);
      exl_clr = ($urandom_range(0, 7) == 0);
      intpc   = $urandom;
      #2;
      check($sformatf("rnd%0d_dout", n), dout, modelRead(a));
      check($sformatf("rnd%0d_epc", n), {2'b00, epc}, {2'b00, mRegs[14][31:2]});
      check($sformatf("rnd%0d_int_req", n), {31'h0, int_req}, {31'h0, modelIrq()});
      @(posedge clk);
      modelEdge(we, addr, din, hw_int, exl_set, exl_clr, intpc);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
